// File: rtl/ram_req_issuer_pkg.sv
// Shared types and constants for the RAM request issuer slice.
//   req_code_e : request codes popped from the request FIFO
//   state_e    : issuer FSM states
//   BURST_LEN  : read beats issued by a BURST request
package ram_req_issuer_pkg;

  typedef enum logic [1:0] {
    REQ_NOP   = 2'b00,
    REQ_READ  = 2'b01,
    REQ_WRITE = 2'b10,
    REQ_BURST = 2'b11
  } req_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10
  } state_e;

  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned BEAT_W    = 2;
  localparam int unsigned RSP_DEPTH = 2;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned CREDIT_W  = 2;
  // Read issue stalls once this many responses are outstanding or buffered.
  localparam int unsigned CREDIT_MAX = RSP_DEPTH;

endpackage

// File: rtl/ram_req_issuer_if.sv
// RAM command/response bus between the request issuer and the RAM.
//   master : issuer side (drives the command, receives grant and read data)
//   slave  : RAM side
interface ram_req_issuer_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
);
  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_gnt;
  logic          ram_rvalid;
  logic [DW-1:0] ram_rdata;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_gnt, ram_rvalid, ram_rdata
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_gnt, ram_rvalid, ram_rdata
  );
endinterface

// File: rtl/ram_rsp_buf.sv
// Two-entry read-response buffer.
//   push/push_data : write an entry (ignored when full)
//   pop/pop_data   : consume the head (pop_data is the head entry)
//   empty/full/count : occupancy status
module ram_rsp_buf
  import ram_req_issuer_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [DW-1:0]    pop_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [RSP_DEPTH-1:0][DW-1:0] mem_q;
  logic                         wr_ptr_q;
  logic                         rd_ptr_q;
  logic [CNT_W-1:0]             count_q;
  logic                         do_push;
  logic                         do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(RSP_DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // Storage, pointers and occupancy; simultaneous push/pop keeps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_req_issuer.sv
// Pops request codes from a FIFO and issues single reads, 4-beat read bursts
// and single writes to a RAM, one request in flight at a time. Read data is
// buffered in a 2-entry response buffer guarded by a credit counter so that
// no read return is ever dropped.
//   fifo_empty/fifo_data/fifo_pop : request FIFO head and pop
//   cfg_load/cfg_base_addr        : address pointer load (any state)
//   wr_valid/wr_data/wr_ready     : write-data offer and acceptance
//   ram                           : RAM command bus (master side)
//   rsp_valid/rsp_data/rsp_ready  : buffered read responses
//   busy                          : FSM not in IDLE
module ram_req_issuer
  import ram_req_issuer_pkg::*;
#(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fifo_empty,
  input  logic [1:0]    fifo_data,
  output logic          fifo_pop,
  input  logic          cfg_load,
  input  logic [AW-1:0] cfg_base_addr,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  ram_req_issuer_if.master ram,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  input  logic          rsp_ready,
  output logic          busy
);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [AW-1:0]       addr_q;
  logic                rd_gnt_q;
  logic                rv_mask_q;
  logic                grant;
  logic [CREDIT_W-1:0] credit;
  logic [CNT_W-1:0]    buf_count;
  logic                buf_empty;
  logic                buf_full;
  logic                buf_push;
  logic                buf_pop;

  // A read granted last cycle has its data in flight and already owns a slot.
  assign credit   = CREDIT_W'(rd_gnt_q) + CREDIT_W'(buf_count);
  assign grant    = ram.ram_req & ram.ram_gnt;
  assign ram.ram_addr = addr_q;
  assign busy     = (state_q != ST_IDLE);

  // Returns for reads issued before a reset are dropped in the first cycle after release.
  assign buf_push  = ram.ram_rvalid & ~rv_mask_q & ~buf_full;
  assign buf_pop   = rsp_valid & rsp_ready;
  assign rsp_valid = ~buf_empty;

  // Next-state and command decode.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    fifo_pop      = 1'b0;
    wr_ready      = 1'b0;
    ram.ram_req   = 1'b0;
    ram.ram_we    = 1'b0;
    ram.ram_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        fifo_pop = ~fifo_empty;
        if (!fifo_empty) begin
          case (req_code_e'(fifo_data))
            REQ_READ: begin
              state_d = ST_RD;
              beat_d  = '0;
            end
            REQ_BURST: begin
              state_d = ST_RD;
              beat_d  = BEAT_W'(BURST_LEN - 1);
            end
            REQ_WRITE: state_d = ST_WR;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_RD: begin
        ram.ram_req = (credit < CREDIT_W'(CREDIT_MAX));
        if (ram.ram_req && ram.ram_gnt) begin
          if (beat_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q - BEAT_W'(1);
          end
        end
      end
      ST_WR: begin
        ram.ram_req   = wr_valid;
        ram.ram_we    = 1'b1;
        ram.ram_wdata = wr_data;
        wr_ready      = wr_valid & ram.ram_gnt;
        if (wr_valid && ram.ram_gnt) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, beat counter, address pointer (load beats increment) and credit tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      addr_q    <= '0;
      rd_gnt_q  <= 1'b0;
      rv_mask_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      rd_gnt_q  <= grant & ~ram.ram_we;
      rv_mask_q <= 1'b0;
      if (cfg_load) begin
        addr_q <= cfg_base_addr;
      end else if (grant) begin
        addr_q <= addr_q + AW'(1);
      end
    end
  end

  ram_rsp_buf #(
    .DW (DW)
  ) u_rsp_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data (ram.ram_rdata),
    .pop       (buf_pop),
    .pop_data  (rsp_data),
    .empty     (buf_empty),
    .full      (buf_full),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_ram_req_issuer.sv
// Self-checking bench for ram_req_issuer: FIFO and RAM models, with a
// scoreboard of expected RAM commands and read responses.
module tb_ram_req_issuer;
  import ram_req_issuer_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic [1:0]    fifo_data;
  logic          fifo_pop;
  logic          cfg_load;
  logic [AW-1:0] cfg_base_addr;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_ready;
  logic          busy;

  ram_req_issuer_if #(.AW(AW), .DW(DW)) ram_if ();

  ram_req_issuer #(.AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .fifo_pop      (fifo_pop),
    .cfg_load      (cfg_load),
    .cfg_base_addr (cfg_base_addr),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .ram           (ram_if.master),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_ready     (rsp_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  cmd_t          exp_cmd[$];
  logic [DW-1:0] exp_rsp[$];
  logic [1:0]    fifo_q[$];
  cmd_t          mon_c;
  logic [DW-1:0] mon_r;
  int            n_cmp = 0;
  int            n_err = 0;
  int            grant_cnt = 0;
  int            wr_cnt = 0;
  int            cyc = 0;
  int            last_rd_cyc = 0;
  int            last_rsp_cyc = 0;
  logic [AW-1:0] mptr;
  logic          s_pop, s_rd;
  logic [AW-1:0] s_addr;

  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    return {20'hC0DE5, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: samples at negedge, scores RAM commands and responses.
  always @(negedge clk) begin
    cyc++;
    s_pop  = rst_n && fifo_pop;
    s_rd   = 1'b0;
    s_addr = ram_if.ram_addr;
    if (rst_n) begin
      if (ram_if.ram_req && ram_if.ram_gnt) begin
        grant_cnt++;
        s_rd = !ram_if.ram_we;
        if (s_rd) last_rd_cyc = cyc;
        if (exp_cmd.size() == 0) begin
          chk("cmd_unexpected", 64'(exp_cmd.size()), 64'd1);
        end else begin
          mon_c = exp_cmd.pop_front();
          chk("cmd_we", 64'(ram_if.ram_we), 64'(mon_c.we));
          chk("cmd_addr", 64'(ram_if.ram_addr), 64'(mon_c.addr));
          if (mon_c.we) chk("cmd_wdata", 64'(ram_if.ram_wdata), 64'(mon_c.wdata));
        end
      end
      if (wr_ready) wr_cnt++;
      if (rsp_valid && rsp_ready) begin
        last_rsp_cyc = cyc;
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 64'(exp_rsp.size()), 64'd1);
        end else begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(mon_r));
        end
      end
    end
  end

  // Environment: FIFO pop and RAM read return one cycle after a read grant.
  always begin
    @(posedge clk);
    #1;
    if (s_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    ram_if.ram_rvalid = s_rd;
    ram_if.ram_rdata  = s_rd ? rdata_of(s_addr) : '0;
    #2;
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 2'b00 : fifo_q[0];
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic exp_read();
    exp_cmd.push_back('{1'b0, mptr, 32'h0});
    exp_rsp.push_back(rdata_of(mptr));
    mptr = mptr + AW'(1);
  endtask

  task automatic push_req(input logic [1:0] code, input logic [DW-1:0] wd);
    fifo_q.push_back(code);
    case (code)
      REQ_READ:  exp_read();
      REQ_BURST: repeat (BURST_LEN) exp_read();
      REQ_WRITE: begin
        exp_cmd.push_back('{1'b1, mptr, wd});
        mptr = mptr + AW'(1);
      end
      default: ;
    endcase
  endtask

  task automatic load_ptr(input logic [AW-1:0] a);
    cfg_load      = 1'b1;
    cfg_base_addr = a;
    mptr          = a;
    step();
    cfg_load      = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && !busy && exp_cmd.size() == 0 &&
          exp_rsp.size() == 0 && !rsp_valid) break;
    end
    if (i == max) chk("drain_timeout", 64'(exp_cmd.size() + exp_rsp.size() + fifo_q.size()), 64'd0);
    step();
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_ram_req"},  64'(ram_if.ram_req), 64'd0);
    chk({pfx, "_ram_we"},   64'(ram_if.ram_we), 64'd0);
    chk({pfx, "_wr_ready"}, 64'(wr_ready), 64'd0);
    chk({pfx, "_rsp_valid"},64'(rsp_valid), 64'd0);
    chk({pfx, "_busy"},     64'(busy), 64'd0);
    chk({pfx, "_ram_addr"}, 64'(ram_if.ram_addr), 64'd0);
    chk({pfx, "_rsp_data"}, 64'(rsp_data), 64'd0);
  endtask

  initial begin
    int g0, w0, req_hi, i;
    rst_n = 1'b0; fifo_empty = 1'b1; fifo_data = 2'b00; cfg_load = 1'b0;
    cfg_base_addr = '0; wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b0;
    ram_if.ram_gnt = 1'b0; ram_if.ram_rvalid = 1'b0; ram_if.ram_rdata = '0;
    mptr = '0;

    // Reset values; fifo_pop follows the FIFO even while in reset.
    @(negedge clk);
    chk_reset_outputs("rst");
    chk("rst_pop_empty", 64'(fifo_pop), 64'd0);
    fifo_q.push_back(REQ_NOP);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pop_nonempty", 64'(fifo_pop), 64'd1);
    step();
    rst_n = 1'b1;
    wait_idle(20);

    // Single read from a loaded base.
    ram_if.ram_gnt = 1'b1; rsp_ready = 1'b1;
    load_ptr(12'h010);
    push_req(REQ_READ, '0);
    wait_idle(50);
    @(negedge clk);
    chk("t1_addr_ptr", 64'(ram_if.ram_addr), 64'h011);
    chk("t1_rsp_latency", 64'(last_rsp_cyc - last_rd_cyc), 64'd2);
    step();

    // Burst with a stalled consumer: credit limits issue to two beats.
    rsp_ready = 1'b0;
    g0 = grant_cnt;
    push_req(REQ_BURST, '0);
    repeat (8) step();
    @(negedge clk);
    chk("t2_stall_grants", 64'(grant_cnt - g0), 64'd2);
    chk("t2_stall_req", 64'(ram_if.ram_req), 64'd0);
    chk("t2_stall_rsp_valid", 64'(rsp_valid), 64'd1);
    step();
    rsp_ready = 1'b1;
    wait_idle(50);
    chk("t2_total_grants", 64'(grant_cnt - g0), 64'd4);

    // Write held off by wr_valid.
    w0 = wr_cnt;
    wr_data = 32'hDEAD_BEEF;
    push_req(REQ_WRITE, 32'hDEAD_BEEF);
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) break;
    end
    chk("t3_entered_wr", 64'(busy), 64'd1);
    req_hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (ram_if.ram_req) req_hi++;
    end
    chk("t3_req_low", 64'(req_hi), 64'd0);
    step();
    wr_valid = 1'b1;
    @(negedge clk);
    chk("t3_wr_ready", 64'(wr_ready), 64'd1);
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("t3_busy_after", 64'(busy), 64'd0);
    chk("t3_wr_ready_after", 64'(wr_ready), 64'd0);
    step();
    chk("t3_wr_pulses", 64'(wr_cnt - w0), 64'd1);

    // Burst across the address wrap.
    load_ptr(12'hFFF);
    push_req(REQ_BURST, '0);
    wait_idle(50);
    @(negedge clk);
    chk("t4_wrap_ptr", 64'(ram_if.ram_addr), 64'h003);
    step();

    // Load coinciding with a read grant wins over the increment.
    ram_if.ram_gnt = 1'b0;
    push_req(REQ_READ, '0);
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_if.ram_req) break;
    end
    chk("t5_req_wait", 64'(ram_if.ram_req), 64'd1);
    step();
    ram_if.ram_gnt = 1'b1; cfg_load = 1'b1; cfg_base_addr = 12'h100;
    step();
    cfg_load = 1'b0; mptr = 12'h100;
    @(negedge clk);
    chk("t5_load_wins", 64'(ram_if.ram_addr), 64'h100);
    wait_idle(50);

    // NOP, NOP, READ pop on consecutive cycles.
    push_req(REQ_NOP, '0);
    push_req(REQ_NOP, '0);
    push_req(REQ_READ, '0);
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_pop) break;
    end
    chk("t5_nop1_req", 64'(ram_if.ram_req), 64'd0);
    @(negedge clk);
    chk("t5_pop2", 64'(fifo_pop), 64'd1);
    chk("t5_nop2_req", 64'(ram_if.ram_req), 64'd0);
    @(negedge clk);
    chk("t5_pop3", 64'(fifo_pop), 64'd1);
    chk("t5_pop3_req", 64'(ram_if.ram_req), 64'd0);
    step();
    wait_idle(50);
    @(negedge clk);
    chk("t5_ptr_after", 64'(ram_if.ram_addr), 64'h101);
    step();

    // Reset after the second beat of a stalled burst.
    rsp_ready = 1'b0;
    g0 = grant_cnt;
    push_req(REQ_BURST, '0);
    for (i = 0; i < 20; i++) begin
      step();
      if (grant_cnt - g0 >= 2) break;
    end
    if (i == 20) chk("t6_wait_timeout", 64'(grant_cnt - g0), 64'd2);
    rst_n = 1'b0;
    fifo_q.delete(); exp_cmd.delete(); exp_rsp.delete(); mptr = '0;
    @(negedge clk);
    chk_reset_outputs("t6");
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rsp_after_rel", 64'(rsp_valid), 64'd0);
    chk("t6_busy_after_rel", 64'(busy), 64'd0);
    step();
    rsp_ready = 1'b1;
    push_req(REQ_READ, '0);
    wait_idle(50);
    @(negedge clk);
    chk("t6_ptr_after", 64'(ram_if.ram_addr), 64'h001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_req_issuer.md
RAM_REQ_ISSUER -- requirements
Module: ram_req_issuer

Interface
REQ-001 Parameter: AW, 12, RAM word-address width.
REQ-002 Parameter: DW, 32, RAM data width.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 fifo_empty  input  1  request FIFO has no entry.
REQ-006 fifo_data  input  2  head request code, valid same cycle as !fifo_empty.
REQ-007 fifo_pop  output  1  consume head request this cycle.
REQ-008 cfg_load  input  1  load address pointer from cfg_base_addr.
REQ-009 cfg_base_addr  input  AW  new address pointer value.
REQ-010 wr_valid / wr_data  input  1 / DW  write-data offer.
REQ-011 wr_ready  output  1  write data accepted this cycle.
REQ-012 ram_req / ram_we / ram_addr / ram_wdata  output  1 / 1 / AW / DW  RAM command.
REQ-013 ram_gnt  input  1  RAM accepts command when ram_req & ram_gnt.
REQ-014 ram_rvalid / ram_rdata  input  1 / DW  read return, exactly 1 cycle after read grant.
REQ-015 rsp_valid / rsp_data  output  1 / DW  buffered read response.
REQ-016 rsp_ready  input  1  response consumer accepts.
REQ-017 busy  output  1  FSM not in IDLE.

Function
REQ-018 Request codes SHALL be: 00 NOP, 01 READ (1 beat), 10 WRITE (1 beat), 11 BURST (4 read beats).
REQ-019 FSM states SHALL be IDLE, RD, WR.
REQ-020 IDLE: fifo_pop = !fifo_empty (combinational); on pop, NOP->IDLE, READ->RD beat_cnt=0, BURST->RD beat_cnt=3, WRITE->WR.
REQ-021 fifo_pop SHALL be 0 outside IDLE; one request in flight at a time, back-to-back pops allowed for consecutive NOPs.
REQ-022 RD: ram_req = (credit < 2), ram_we=0, ram_addr=addr_ptr; on grant beat_cnt==0 -> IDLE else beat_cnt-1, stay RD.
REQ-023 WR: ram_req=wr_valid, ram_we=1, ram_wdata=wr_data, wr_ready=wr_valid & ram_gnt; on grant -> IDLE.
REQ-024 wr_ready SHALL be 0 outside WR; ram_req SHALL be 0 in IDLE.
REQ-025 addr_ptr SHALL increment by 1 per granted beat, wrapping mod 2^AW (max -> 0).
REQ-026 cfg_load SHALL load addr_ptr in any state; simultaneous with grant, load wins (no increment).
REQ-027 credit = reads granted last cycle (0/1) + response buffer occupancy; read issue blocked at credit 2, so no response is ever dropped.
REQ-028 Response buffer: 2 entries, ram_rdata written on ram_rvalid; rsp_valid = occupancy>0, rsp_data = head; pop on rsp_valid & rsp_ready; push and pop same cycle SHALL keep occupancy.
REQ-029 Grant latency SHALL be unbounded; ram_req, ram_we, ram_addr, ram_wdata SHALL hold stable until granted (except addr on cfg_load).
REQ-030 busy = (state != IDLE).

Reset
REQ-031 On rst_n low: state IDLE, addr_ptr 0, beat_cnt 0, buffer empty, credit 0.
REQ-032 Reset outputs: fifo_pop per REQ-020, ram_req 0, ram_we 0, wr_ready 0, rsp_valid 0, busy 0; ram_addr 0, rsp_data 0.
REQ-033 Reset mid-burst SHALL abandon remaining beats and discard buffered responses; a late ram_rvalid SHALL be ignored for one cycle after reset release.

Structure
REQ-034 Shared dnoc package SHALL hold the request-code enum (NOP/READ/WRITE/BURST), FSM state enum, and BURST_LEN=4.
REQ-035 Response buffer SHALL be sub-module ram_rsp_buf (2-entry, DW-wide, push/pop/empty/full/count).

Verification
REQ-036 addr loaded 0x010, FIFO {READ}, gnt=1, rsp_ready=1 -> one req addr 0x010 we=0, rsp_data = ram_rdata one cycle later, addr_ptr 0x011.
REQ-037 BURST, gnt=1, rsp_ready=0 -> only 2 beats granted, ram_req low; raise rsp_ready -> beats 3,4 issued, 4 responses in order, addresses base..base+3.
REQ-038 WRITE with wr_valid low 5 cycles, gnt=1 -> ram_req low 5 cycles, then one write, wr_ready pulses once, FSM IDLE next cycle.
REQ-039 addr_ptr 0xFFF, BURST -> addresses 0xFFF, 0x000, 0x001, 0x002.
REQ-040 cfg_load=0x100 in same cycle as read grant -> addr_ptr=0x100 next cycle; FIFO {NOP,NOP,READ} -> pops on three consecutive cycles, no ram_req for NOPs.
REQ-041 rst_n asserted after beat 2 of BURST -> all outputs reset values, rsp_valid 0, next FIFO request processed normally after release.
